pll_lock_ctrl: RTL and testbench

Reset and lock sequencer for the EG PLL wrappers (e.g. `pll_200_16`). It drives the PLL's active-high `reset` pin and consumes its asynchronous `extlock`. It also releases the SoC system reset only after lock has been continuously stable, and re-runs the PLL reset sequence on lock loss or on software request. It runs on the free-running board reference clock, the same 50 MHz `refclk` that feeds the PLL, so it never depends on PLL output clocks.

---
 rtl/pll_lock_ctrl_pkg.sv | 7 +
 rtl/pll_lock_ctrl_sync_2ff.sv | 12 +
 rtl/pll_lock_ctrl.sv | 99 +++++++++
 tb/tb_pll_lock_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_ctrl_pkg.sv
// pll_lock_ctrl_pkg: shared state encoding and counter widths for the PLL lock sequencer
package pll_lock_ctrl_pkg;
  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
  localparam int RETRY_W = 4;
  localparam int LOSS_W = 8;
  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;
endpackage

// File: rtl/pll_lock_ctrl_sync_2ff.sv
// sync_2ff: generic two-flop synchronizer, async active-low reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else        {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset/lock sequencer and system reset release on refclk.
// Optional RUN-state lock-loss glitch filter: PLL_LOCK_CTRL_GLITCH_FILTER_EN.
module pll_lock_ctrl
  import pll_lock_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 4,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic               refclk,
  input  logic               reset_n,
  input  logic               extlock,
  input  logic               relock_req,
  output logic               pll_reset,
  output logic               sys_rst_n,
  output logic               locked,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt
);
  localparam int TMAX = (RST_CYCLES > LOCK_TIMEOUT)
                        ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
                        : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  state_t             state;
  logic [TW-1:0]      tmr;
  logic               lock_s;
  logic               run_loss;
  logic [RETRY_W-1:0] retry_nxt;
  sync_2ff u_sync (.clk(refclk), .rst_n(reset_n), .d(extlock), .q(lock_s));
`ifdef PLL_LOCK_CTRL_GLITCH_FILTER_EN
  localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES + 1) : 1;
  logic [GW-1:0] gcnt;
  always_ff @(posedge refclk or negedge reset_n)
    if (!reset_n) gcnt <= '0;
    else          gcnt <= (state == RUN && !lock_s && !run_loss) ? gcnt + 1'b1 : '0;
  assign run_loss = state == RUN && !lock_s && gcnt == GW'(GLITCH_CYCLES - 1);
`else
  assign run_loss = state == RUN && !lock_s;
`endif
  assign retry_nxt = retry_cnt + 1'b1;
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RESET_PLL;
      tmr       <= '0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      locked    <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      if (run_loss && loss_cnt != LOSS_MAX) loss_cnt <= loss_cnt + 1'b1;
      // relock and RUN lock loss share one restart path; relock also wipes retries
      if ((relock_req && state != RESET_PLL) || run_loss) begin
        state     <= RESET_PLL;
        tmr       <= '0;
        pll_reset <= 1'b1;
        sys_rst_n <= 1'b0;
        locked    <= 1'b0;
        fail      <= 1'b0;
        if (relock_req) retry_cnt <= '0;
      end else begin
        case (state)
          RESET_PLL:
            if (tmr == TW'(RST_CYCLES - 1)) begin
              state     <= WAIT_LOCK;
              tmr       <= '0;
              pll_reset <= 1'b0;
            end else tmr <= tmr + 1'b1;
          WAIT_LOCK:
            if (lock_s) begin
              state <= STABLE;
              tmr   <= '0;
            end else if (tmr == TW'(LOCK_TIMEOUT - 1)) begin
              retry_cnt <= retry_nxt;
              tmr       <= '0;
              pll_reset <= 1'b1;
              fail      <= retry_nxt == RETRY_W'(MAX_RETRY);
              state     <= (retry_nxt == RETRY_W'(MAX_RETRY)) ? FAIL : RESET_PLL;
            end else tmr <= tmr + 1'b1;
          STABLE:
            if (!lock_s) begin
              state <= WAIT_LOCK;
              tmr   <= '0;
            end else if (tmr == TW'(STABLE_CYCLES - 1)) begin
              state     <= RUN;
              retry_cnt <= '0;
              sys_rst_n <= 1'b1;
              locked    <= 1'b1;
            end else tmr <= tmr + 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: directed checks of the PLL lock sequencer (two instances, short/long stable windows)
module tb_pll_lock_ctrl;
  logic       refclk;
  logic       reset_n;
  logic       extlock, relock_req, extlock2, relock2;
  logic       pll_reset, sys_rst_n, locked, fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic       pll_reset2, sys_rst_n2, locked2, fail2;
  logic [3:0] retry_cnt2;
  logic [7:0] loss_cnt2;
  int         errors = 0;
  int         checks = 0;

  pll_lock_ctrl #(.LOCK_TIMEOUT(100)) dut (
    .refclk(refclk), .reset_n(reset_n), .extlock(extlock), .relock_req(relock_req),
    .pll_reset(pll_reset), .sys_rst_n(sys_rst_n), .locked(locked), .fail(fail),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  pll_lock_ctrl #(.LOCK_TIMEOUT(100), .STABLE_CYCLES(8)) dut2 (
    .refclk(refclk), .reset_n(reset_n), .extlock(extlock2), .relock_req(relock2),
    .pll_reset(pll_reset2), .sys_rst_n(sys_rst_n2), .locked(locked2), .fail(fail2),
    .retry_cnt(retry_cnt2), .loss_cnt(loss_cnt2)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_reset"}, pll_reset, 1);
    chk({tag, "_sys_rst_n"}, sys_rst_n, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_retry"}, retry_cnt, 0);
    chk({tag, "_loss"}, loss_cnt, 0);
    chk({tag, "_loss2"}, loss_cnt2, 0);
  endtask

  initial begin
    reset_n = 0; extlock = 0; relock_req = 0; extlock2 = 0; relock2 = 0;
    tick(3);
    chk_reset_vals("rst");
    reset_n = 1;
    // nominal lock: extlock rises 100 cycles after release
    tick(15);
    chk("pll_rst_hold15", pll_reset, 1);
    tick(1);
    chk("pll_rst_rel16", pll_reset, 0);
    tick(84);
    extlock = 1;
    tick(1026);
    chk("nom_sys_pre", sys_rst_n, 0);
    chk("nom_lock_pre", locked, 0);
    tick(1);
    chk("nom_sys", sys_rst_n, 1);
    chk("nom_locked", locked, 1);
    chk("nom_retry", retry_cnt, 0);
    chk("nom_pll_rst", pll_reset, 0);
    // single-cycle lock drop in RUN
    extlock = 0;
    tick(1);
    extlock = 1;
`ifdef PLL_LOCK_CTRL_GLITCH_FILTER_EN
    tick(5);
    chk("glitch_locked", locked, 1);
    chk("glitch_loss", loss_cnt, 0);
    extlock = 0;
    tick(5);
    chk("long_drop_pre", locked, 1);
    tick(1);
    chk("long_drop_locked", locked, 0);
    chk("long_drop_loss", loss_cnt, 1);
    chk("long_drop_pll_rst", pll_reset, 1);
    extlock = 1;
`else
    tick(1);
    chk("drop_pre", locked, 1);
    tick(1);
    chk("drop_locked", locked, 0);
    chk("drop_sys", sys_rst_n, 0);
    chk("drop_pll_rst", pll_reset, 1);
    chk("drop_loss", loss_cnt, 1);
`endif
    tick(1040);
    chk("relock_pre", locked, 0);
    tick(1);
    chk("relock_run", locked, 1);
    // lock lost at STABLE cycle 500 restarts the full stable window
    relock_req = 1;
    tick(1);
    relock_req = 0;
    chk("req_pll_rst", pll_reset, 1);
    chk("req_sys", sys_rst_n, 0);
    chk("req_loss_kept", loss_cnt, 1);
    tick(517);
    extlock = 0;
    tick(1);
    extlock = 1;
    tick(2);
    chk("stb_drop_retry", retry_cnt, 0);
    tick(1024);
    chk("stb_restart_pre", locked, 0);
    tick(1);
    chk("stb_restart_run", locked, 1);
    chk("stb_loss", loss_cnt, 1);
    // retries to FAIL with extlock held low
    relock_req = 1;
    extlock = 0;
    tick(1);
    relock_req = 0;
    tick(116);
    chk("retry1", retry_cnt, 1);
    chk("retry1_pll_rst", pll_reset, 1);
    tick(116);
    chk("retry2", retry_cnt, 2);
    tick(116);
    chk("retry3", retry_cnt, 3);
    tick(115);
    chk("retry3_wait", retry_cnt, 3);
    chk("retry3_fail", fail, 0);
    chk("retry3_pll_rst", pll_reset, 0);
    tick(1);
    chk("retry4", retry_cnt, 4);
    chk("fail_set", fail, 1);
    chk("fail_pll_rst", pll_reset, 1);
    chk("fail_sys", sys_rst_n, 0);
    tick(50);
    chk("fail_hold", fail, 1);
    chk("fail_hold_retry", retry_cnt, 4);
    // recover from FAIL
    relock_req = 1;
    tick(1);
    relock_req = 0;
    chk("recover_retry", retry_cnt, 0);
    chk("recover_fail", fail, 0);
    chk("recover_pll_rst", pll_reset, 1);
    extlock = 1;
    tick(1040);
    chk("recover_pre", locked, 0);
    tick(1);
    chk("recover_run", locked, 1);
    // relock_req coinciding with a RUN lock loss
    extlock = 0;
    tick(2);
    relock_req = 1;
    tick(1);
    relock_req = 0;
`ifdef PLL_LOCK_CTRL_GLITCH_FILTER_EN
    chk("both_loss", loss_cnt, 1);
`else
    chk("both_loss", loss_cnt, 2);
`endif
    chk("both_pll_rst", pll_reset, 1);
    chk("both_locked", locked, 0);
    extlock = 1;
    // async reset mid-STABLE
    tick(300);
    chk("mid_stable_locked", locked, 0);
    chk("mid_stable_pll_rst", pll_reset, 0);
    #2;
    reset_n = 0;
    extlock2 = 1;
    #1;
    chk_reset_vals("async");
    // loss counter saturation on the short-window instance
    tick(2);
    reset_n = 1;
    for (int i = 0; i < 300; i++) begin
      for (int n = 0; n < 300 && !locked2; n++) tick(1);
      chk("sat_lock_wait", locked2, 1);
      if (i == 1 || i == 254 || i == 255) chk("sat_loss_step", loss_cnt2, i);
      extlock2 = 0;
      tick(8);
      extlock2 = 1;
    end
    for (int n = 0; n < 300 && !locked2; n++) tick(1);
    chk("sat_final_lock", locked2, 1);
    chk("sat_loss", loss_cnt2, 255);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
